matmul_host_loader: RTL

- Host-side driver for the external (port 1) side of the 4x4 matmul block's three dual-port BRAMs.
- Accepts a valid/ready stream of 32-bit packed rows and writes 4 rows of A, then 4 rows of B.
- Pulses start_reg, waits for the done indication, then reads the 4 rows of C back out as a valid/ready stream.
- Finishes by pulsing clear_done_reg so the matmul FSM returns to idle.

---
 rtl/matmul_host_loader.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/matmul_host_loader.sv
// matmul_host_loader: host-side driver for the external port of the 4x4 matmul
// BRAMs. It streams 4 rows of A and 4 rows of B in, pulses start, waits for done,
// streams the 4 rows of C back out, then pulses clear_done.
// Optional build macro MATMUL_HOST_CHECKSUM_EN adds a 32-bit running checksum
// output covering every C row handed downstream.
module matmul_host_loader #(
  parameter int DWIDTH       = 8,
  parameter int AWIDTH       = 11,
  parameter int MAT_MUL_SIZE = 4,
  parameter int MASK_WIDTH   = 4
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           go,
  input  logic [AWIDTH-1:0]              base_a,
  input  logic [AWIDTH-1:0]              base_b,
  input  logic [AWIDTH-1:0]              base_c,
  input  logic [7:0]                     stride_a,
  input  logic [7:0]                     stride_b,
  input  logic [7:0]                     stride_c,
  input  logic [MAT_MUL_SIZE*DWIDTH-1:0] in_data,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [MAT_MUL_SIZE*DWIDTH-1:0] out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [AWIDTH-1:0]              bram_addr_a_ext,
  output logic [AWIDTH-1:0]              bram_addr_b_ext,
  output logic [AWIDTH-1:0]              bram_addr_c_ext,
  output logic [MAT_MUL_SIZE*DWIDTH-1:0] bram_wdata_a_ext,
  output logic [MAT_MUL_SIZE*DWIDTH-1:0] bram_wdata_b_ext,
  output logic [MASK_WIDTH-1:0]          bram_we_a_ext,
  output logic [MASK_WIDTH-1:0]          bram_we_b_ext,
  output logic [MAT_MUL_SIZE*DWIDTH-1:0] bram_wdata_c_ext,
  output logic [MASK_WIDTH-1:0]          bram_we_c_ext,
  input  logic [MAT_MUL_SIZE*DWIDTH-1:0] bram_rdata_c_ext,
  output logic                           start_reg,
  output logic                           clear_done_reg,
  input  logic                           done_in,
  output logic                           busy
`ifdef MATMUL_HOST_CHECKSUM_EN
  ,
  output logic [31:0]                    checksum
`endif
);

  localparam int RW = MAT_MUL_SIZE * DWIDTH;
  localparam int CW = $clog2(MAT_MUL_SIZE + 1);
  localparam logic [CW-1:0] LAST_ROW = CW'(MAT_MUL_SIZE - 1);
  localparam logic [CW-1:0] NUM_ROWS = CW'(MAT_MUL_SIZE);

  typedef enum logic [2:0] {
    IDLE, LOAD_A, LOAD_B, START, WAIT_DONE, READ_C, CLEAR
  } state_t;

  state_t            state_reg;
  logic [AWIDTH-1:0] addr_reg;      // running row address for the active matrix
  logic [CW-1:0]     row_reg;       // rows written (load) or reads issued (unload)
  logic [CW-1:0]     pop_reg;       // C rows handed downstream
  logic              inflight_reg;  // a C read was issued last cycle
  logic [RW-1:0]     fifo_mem [2];
  logic              wr_ptr_reg;
  logic              rd_ptr_reg;
  logic [1:0]        count_reg;

  logic          handshake;
  logic          last_row;
  logic          issue;
  logic          push;
  logic          pop;
  logic [1:0]    occupancy;

  // Writes are gated by resetn so an abort never lands a stray row in BRAM.
  assign handshake = in_valid & in_ready & resetn;
  assign last_row  = (row_reg == LAST_ROW);

  // Reads in flight count against FIFO space so out_ready=0 can never overflow it.
  assign occupancy = count_reg + {1'b0, inflight_reg};
  assign issue     = (state_reg == READ_C) && (row_reg < NUM_ROWS) && (occupancy < 2'd2);
  assign push      = inflight_reg;
  assign out_valid = (count_reg != 2'd0);
  assign pop       = out_valid & out_ready;
  assign out_data  = out_valid ? fifo_mem[rd_ptr_reg] : '0;

  assign bram_we_a_ext    = (state_reg == LOAD_A && handshake) ? '1 : '0;
  assign bram_we_b_ext    = (state_reg == LOAD_B && handshake) ? '1 : '0;
  assign bram_wdata_a_ext = (state_reg == LOAD_A && handshake) ? in_data : '0;
  assign bram_wdata_b_ext = (state_reg == LOAD_B && handshake) ? in_data : '0;
  assign bram_addr_a_ext  = (state_reg == LOAD_A) ? addr_reg : '0;
  assign bram_addr_b_ext  = (state_reg == LOAD_B) ? addr_reg : '0;
  assign bram_addr_c_ext  = (state_reg == READ_C) ? addr_reg : '0;
  assign bram_wdata_c_ext = '0;
  assign bram_we_c_ext    = '0;

  // Job sequencer: load A, load B, start, wait, unload C, clear.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg      <= IDLE;
      addr_reg       <= '0;
      row_reg        <= '0;
      pop_reg        <= '0;
      in_ready       <= 1'b0;
      start_reg      <= 1'b0;
      clear_done_reg <= 1'b0;
      busy           <= 1'b0;
    end else begin
      start_reg      <= 1'b0;
      clear_done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (go) begin
            state_reg <= LOAD_A;
            addr_reg  <= base_a;
            row_reg   <= '0;
            pop_reg   <= '0;
            in_ready  <= 1'b1;
            busy      <= 1'b1;
          end
        end
        LOAD_A: begin
          if (handshake) begin
            if (last_row) begin
              state_reg <= LOAD_B;
              addr_reg  <= base_b;
              row_reg   <= '0;
            end else begin
              addr_reg <= addr_reg + AWIDTH'(stride_a);
              row_reg  <= row_reg + 1'b1;
            end
          end
        end
        LOAD_B: begin
          if (handshake) begin
            if (last_row) begin
              state_reg <= START;
              row_reg   <= '0;
              in_ready  <= 1'b0;
              start_reg <= 1'b1;
            end else begin
              addr_reg <= addr_reg + AWIDTH'(stride_b);
              row_reg  <= row_reg + 1'b1;
            end
          end
        end
        START: begin
          state_reg <= WAIT_DONE;
        end
        WAIT_DONE: begin
          // A done level that is already high here can only belong to this job.
          if (done_in) begin
            state_reg <= READ_C;
            addr_reg  <= base_c;
            row_reg   <= '0;
            pop_reg   <= '0;
          end
        end
        READ_C: begin
          if (issue) begin
            addr_reg <= addr_reg + AWIDTH'(stride_c);
            row_reg  <= row_reg + 1'b1;
          end
          if (pop) begin
            pop_reg <= pop_reg + 1'b1;
            if (pop_reg == LAST_ROW) begin
              state_reg      <= CLEAR;
              clear_done_reg <= 1'b1;
            end
          end
        end
        CLEAR: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Track the read issued last cycle and the FIFO pointers/occupancy.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      inflight_reg <= 1'b0;
      wr_ptr_reg   <= 1'b0;
      rd_ptr_reg   <= 1'b0;
      count_reg    <= 2'd0;
    end else begin
      inflight_reg <= issue;
      if (push) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fifo
      // Capture C read data into this FIFO slot when the write pointer selects it.
      always_ff @(posedge clk) begin
        if (!resetn) begin
          fifo_mem[gi] <= '0;
        end else if (push && (wr_ptr_reg == 1'(gi))) begin
          fifo_mem[gi] <= bram_rdata_c_ext;
        end
      end
    end
  endgenerate

`ifdef MATMUL_HOST_CHECKSUM_EN
  // Running wrap-around sum of delivered C rows; restarts when a job is accepted.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      checksum <= '0;
    end else if (state_reg == IDLE && go) begin
      checksum <= '0;
    end else if (pop) begin
      checksum <= checksum + 32'(out_data);
    end
  end
`endif

endmodule
